// File: rtl/nor_bist_pkg.sv
// Shared types and constants for the NOR-chain BIST sequencer.
package nor_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  localparam int unsigned NUM_VECTORS = 16;
  localparam logic [3:0]  LAST_VEC    = 4'(NUM_VECTORS - 1);

  // Chain input positions within the 4-bit vector
  localparam int unsigned VEC_A_BIT = 3;
  localparam int unsigned VEC_B_BIT = 2;
  localparam int unsigned VEC_C_BIT = 1;
  localparam int unsigned VEC_D_BIT = 0;

endpackage

// File: rtl/nor_chain_model.sv
// Combinational golden model of the three-stage NOR chain: {e,f,g} from vector {a,b,c,d}.
module nor_chain_model
  import nor_bist_pkg::*;
(
  input  logic [3:0] vec_i,
  output logic [2:0] efg_o
);

  logic e, f, g;

  always_comb begin
    e     = ~(vec_i[VEC_A_BIT] | vec_i[VEC_B_BIT]);
    f     = ~(e | vec_i[VEC_C_BIT]);
    g     = ~(f | vec_i[VEC_D_BIT]);
    efg_o = {e, f, g};
  end

endmodule

// File: rtl/nor_chain_bist.sv
// BIST sequencer: walks all 16 vectors through the NOR chain and compares against the golden model.
module nor_chain_bist
  import nor_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  output logic       dut_d,
  input  logic       dut_e,
  input  logic       dut_f,
  input  logic       dut_g,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] settle_q, settle_d;
  logic [4:0] err_q, err_d;
  logic       fvalid_q, fvalid_d;
  logic [3:0] fvec_q, fvec_d;
  logic       pass_q, pass_d;

  logic [2:0] model_efg;
  logic       mismatch;
  logic       active;

  nor_chain_model u_model (
    .vec_i (vec_q),
    .efg_o (model_efg)
  );

  assign mismatch = ({dut_e, dut_f, dut_g} != model_efg);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;
    pass_d   = pass_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = APPLY;
          vec_d    = '0;
          err_d    = '0;
          fvalid_d = 1'b0;
          fvec_d   = '0;
          pass_d   = 1'b0;
        end
      end
      APPLY: begin
        settle_d = '0;
        if (abort)                   state_d = IDLE;
        else if (SETTLE_CYCLES == 0) state_d = CHECK;
        else                         state_d = SETTLE;
      end
      SETTLE: begin
        if (abort)                        state_d = IDLE;
        else if (settle_q == SETTLE_LAST) state_d = CHECK;
        else                              settle_d = settle_q + 4'd1;
      end
      CHECK: begin
        // An abort takes priority, so the aborted vector's comparison is not recorded
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (mismatch) begin
            err_d = err_q + 5'd1;
            if (!fvalid_q) begin
              fvalid_d = 1'b1;
              fvec_d   = vec_q;
            end
          end
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
            pass_d  = (err_d == 5'd0);
          end else begin
            vec_d   = vec_q + 4'd1;
            state_d = APPLY;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
      pass_q   <= pass_d;
    end
  end

  assign active     = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
  assign busy       = active;
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fvalid_q;
  assign fail_vec   = fvec_q;
  assign dut_a      = active & vec_q[VEC_A_BIT];
  assign dut_b      = active & vec_q[VEC_B_BIT];
  assign dut_c      = active & vec_q[VEC_C_BIT];
  assign dut_d      = active & vec_q[VEC_D_BIT];

endmodule

// File: tb/tb_nor_chain_bist.sv
// Self-checking bench: two sequencers (settle 1 and 0) each driving a fault-injectable chain model.
module tb_nor_chain_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] start, abort;

  logic a_s1, b_s1, c_s1, d_s1, e_s1, f_s1, g_s1, busy_s1, done_s1, pass_s1, fval_s1;
  logic a_s0, b_s0, c_s0, d_s0, e_s0, f_s0, g_s0, busy_s0, done_s0, pass_s0, fval_s0;
  logic [4:0] ec_s1, ec_s0;
  logic [3:0] fv_s1, fv_s0;

  logic [2:0] xm0 [16];
  logic [2:0] xm1 [16];
  logic [2:0] st_en0, st_val0, st_en1, st_val1;

  int vectors     = 0;
  int miscompares = 0;

  nor_chain_bist #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .dut_a(a_s1), .dut_b(b_s1), .dut_c(c_s1), .dut_d(d_s1),
    .dut_e(e_s1), .dut_f(f_s1), .dut_g(g_s1),
    .busy(busy_s1), .done(done_s1), .pass(pass_s1), .err_count(ec_s1),
    .fail_valid(fval_s1), .fail_vec(fv_s1)
  );

  nor_chain_bist #(.SETTLE_CYCLES(0)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .dut_a(a_s0), .dut_b(b_s0), .dut_c(c_s0), .dut_d(d_s0),
    .dut_e(e_s0), .dut_f(f_s0), .dut_g(g_s0),
    .busy(busy_s0), .done(done_s0), .pass(pass_s0), .err_count(ec_s0),
    .fail_valid(fval_s0), .fail_vec(fv_s0)
  );

  // Truth of the chain from arithmetic on the vector value
  function automatic logic [2:0] golden(input logic [3:0] v);
    int   n;
    logic e, f, g;
    n = int'(v);
    e = (n < 4);
    f = (n >= 4) && (((n / 2) % 2) == 0);
    g = !f && ((n % 2) == 0);
    return {e, f, g};
  endfunction

  function automatic logic [2:0] fault(input logic [2:0] r, input logic [2:0] en, input logic [2:0] val);
    return (r & ~en) | (val & en);
  endfunction

  assign {e_s1, f_s1, g_s1} = fault(golden({a_s1, b_s1, c_s1, d_s1}) ^ xm0[{a_s1, b_s1, c_s1, d_s1}], st_en0, st_val0);
  assign {e_s0, f_s0, g_s0} = fault(golden({a_s0, b_s0, c_s0, d_s0}) ^ xm1[{a_s0, b_s0, c_s0, d_s0}], st_en1, st_val1);

  logic [5:0]  tim [2];
  logic [10:0] res [2];
  always_comb begin
    tim[0] = {busy_s1, done_s1, a_s1, b_s1, c_s1, d_s1};
    tim[1] = {busy_s0, done_s0, a_s0, b_s0, c_s0, d_s0};
    res[0] = {pass_s1, fval_s1, ec_s1, fv_s1};
    res[1] = {pass_s0, fval_s0, ec_s0, fv_s0};
  end

  function automatic logic [2:0] faulty(input int u, input logic [3:0] v);
    if (u == 0) return fault(golden(v) ^ xm0[v], st_en0, st_val0);
    return fault(golden(v) ^ xm1[v], st_en1, st_val1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int v = 0; v < 16; v++) begin
      xm0[v] = 3'b000;
      xm1[v] = 3'b000;
    end
    st_en0 = 3'b000; st_val0 = 3'b000;
    st_en1 = 3'b000; st_val1 = 3'b000;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tim0"}, 32'(tim[0]), 32'd0);
    chk({tag, "_res0"}, 32'(res[0]), 32'd0);
    chk({tag, "_tim1"}, 32'(tim[1]), 32'd0);
    chk({tag, "_res1"}, 32'(res[1]), 32'd0);
  endtask

  // One run on unit u (settle s); abort_at/glitch_at are cycle numbers, 0 = none
  task automatic run(input int u, input int s, input int abort_at, input int glitch_at);
    int   t, last, nchk, exp_err, exp_fv;
    logic exp_valid;
    t    = 2 + s;
    last = 16 * t + 1;
    nchk = 16;
    if (abort_at > 0) begin
      nchk = 0;
      for (int k = 0; k < 16; k++) if ((k + 1) * t < abort_at) nchk++;
    end
    exp_err = 0; exp_fv = 0; exp_valid = 1'b0;
    for (int v = 0; v < nchk; v++) begin
      if (faulty(u, 4'(v)) != golden(4'(v))) begin
        exp_err++;
        if (!exp_valid) begin
          exp_valid = 1'b1;
          exp_fv    = v;
        end
      end
    end
    @(negedge clk);
    chk("idle_pre", 32'(tim[u]), 32'd0);
    start[u] = 1'b1;
    for (int cyc = 1; cyc <= last + 1; cyc++) begin
      logic       act;
      logic [5:0] e;
      @(negedge clk);
      start[u] = 1'b0;
      abort[u] = 1'b0;
      act = (abort_at == 0 || cyc <= abort_at) && (cyc <= 16 * t);
      e   = {act, (abort_at == 0 && cyc == last), act ? 4'((cyc - 1) / t) : 4'd0};
      chk($sformatf("timing u%0d c%0d", u, cyc), 32'(tim[u]), 32'(e));
      if (cyc == glitch_at) start[u] = 1'b1;
      if (cyc == abort_at)  abort[u] = 1'b1;
    end
    chk($sformatf("result u%0d", u), 32'(res[u]),
        32'({(abort_at == 0 && exp_err == 0), exp_valid, 5'(exp_err), 4'(exp_fv)}));
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    abort = '0;
    clear_faults();

    repeat (2) @(negedge clk);
    chk_all_zero("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_rel");

    // Fault-free, settle 1, start re-pulsed mid-run
    run(0, 1, 0, 20);
    chk("ff_pass", 32'(pass_s1), 32'd1);
    chk("ff_err", 32'(ec_s1), 32'd0);
    chk("ff_fval", 32'(fval_s1), 32'd0);

    // g stuck at 0
    st_en0 = 3'b001; st_val0 = 3'b000;
    run(0, 1, 0, 0);
    chk("g0_err", 32'(ec_s1), 32'd5);
    chk("g0_fvec", 32'(fv_s1), 32'd0);
    chk("g0_pass", 32'(pass_s1), 32'd0);

    // e stuck at 1
    st_en0 = 3'b100; st_val0 = 3'b100;
    run(0, 1, 0, 0);
    chk("e1_err", 32'(ec_s1), 32'd12);
    chk("e1_fvec", 32'(fv_s1), 32'd4);
    chk("e1_pass", 32'(pass_s1), 32'd0);

    // Settle 0, fault-free
    clear_faults();
    run(1, 0, 0, 7);
    chk("s0_pass", 32'(pass_s0), 32'd1);

    // Abort at cycle 10 with g stuck at 0: vectors 0..2 checked, 0 and 2 fail
    st_en0 = 3'b001; st_val0 = 3'b000;
    run(0, 1, 10, 5);
    chk("ab_err", 32'(ec_s1), 32'd2);
    chk("ab_pass", 32'(pass_s1), 32'd0);
    clear_faults();
    run(0, 1, 0, 0);
    chk("ab_rerun_pass", 32'(pass_s1), 32'd1);

    // Randomised fault tables, aborts and start glitches
    for (int i = 0; i < 8; i++) begin
      int u, s, ab, gl;
      u = int'($urandom_range(0, 1));
      s = (u == 0) ? 1 : 0;
      clear_faults();
      for (int v = 0; v < 16; v++) begin
        logic [2:0] m;
        m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        if (u == 0) xm0[v] = m;
        else        xm1[v] = m;
      end
      ab = 0;
      gl = 0;
      if ($urandom_range(0, 1) == 1) begin
        ab = int'($urandom_range(1, 16 * (2 + s)));
        if (ab % (2 + s) == 0) ab--;
      end else begin
        gl = int'($urandom_range(1, 16 * (2 + s) + 1));
      end
      run(u, s, ab, gl);
    end

    // Asynchronous reset mid-run
    clear_faults();
    st_en0 = 3'b001; st_val0 = 3'b000;
    @(negedge clk);
    start[0] = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    chk("pre_rst_busy", 32'(busy_s1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_after");
    clear_faults();
    run(0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nor_chain_bist.md
# nor_chain_bist

Built-in self-test sequencer for the three-stage NOR chain (outputs e = ~(a|b), f = ~(e|c), g = ~(f|d)). On a start request it drives all 16 input combinations onto the chain, waits a programmable settle time, and compares the three chain outputs against an internal golden model. It reports pass/fail, the error count and the first failing vector. It sits between the lab's control logic (switches/buttons) and the chain instance, and owns the chain's inputs while a run is active.

## Interface
- SETTLE_CYCLES, 1: wait cycles between applying a vector and sampling outputs; legal range 0..15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  synchronous abort of an active run.
- dut_a, dut_b, dut_c, dut_d  out  1 each  chain inputs; dut_a is vector bit 3, dut_d is vector bit 0.
- dut_e, dut_f, dut_g  in  1 each  chain outputs under test.
- busy  out  1  high from APPLY through CHECK.
- done  out  1  one-cycle pulse at the end of a completed run.
- pass  out  1  err_count==0 for the last completed run; held until the next start.
- err_count  out  5  number of mismatching vectors (0..16); held until the next start.
- fail_valid  out  1  at least one mismatch seen in the current or last run.
- fail_vec  out  4  index of the first mismatching vector; 0 when fail_valid=0.

## Operation
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE: dut_* = 0. If start=1, go to APPLY. On that transition: vec=0, err_count=0, fail_valid=0, fail_vec=0, pass=0.
- APPLY (1 cycle): the vec register drives dut_*. Go to SETTLE if SETTLE_CYCLES>0, else go to CHECK.
- SETTLE: count SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (1 cycle): compare {dut_e,dut_f,dut_g} with model(vec).
  - On mismatch: err_count+1. If fail_valid=0, set fail_vec=vec and fail_valid=1.
  - If vec==15, go to DONE. Otherwise vec+1 and go to APPLY.
- DONE (1 cycle): done=1, pass=(err_count==0). Go to IDLE.
- dut_* hold the vec register value, stable from APPLY through CHECK. They return to 0 in DONE and IDLE.
- vec is a 4-bit counter. The 15->0 wrap never occurs, because CHECK at vec=15 exits to DONE.
- err_count is 5 bits and reaches at most 16, so it needs no saturation.
- start while not in IDLE is ignored. start during DONE is ignored and must be reasserted in IDLE.
- abort in APPLY/SETTLE/CHECK: the next state is IDLE and dut_*=0. done is not pulsed, pass stays 0, and err_count/fail_* keep their partial values. abort in IDLE or DONE has no effect.
- If start and abort are both high in IDLE, start wins, because abort only acts on an active run.

## Timing
- Reset (asynchronous, any state): state=IDLE and all outputs 0 (dut_*, busy, done, pass, err_count, fail_valid, fail_vec). Reset mid-run discards the run.
- Let S = SETTLE_CYCLES. If start is sampled at edge 0, vector k is in APPLY at cycle 1+k(2+S) and in CHECK at cycle (k+1)(2+S).
- DONE (done=1) occurs at cycle 16(2+S)+1: cycle 49 for S=1, cycle 33 for S=0. The earliest next start is sampled in IDLE at cycle 16(2+S)+2.
- CHECK samples the DUT outputs at least S+1 cycles after the vector changes. The chain is combinational, so there is no latency constraint beyond that.

## Structure
- Package nor_bist_pkg holds the state enum (IDLE, APPLY, SETTLE, CHECK, DONE), the NUM_VECTORS=16 constant and the vector bit-position constants.
- Sub-module nor_chain_model is the combinational golden model: 4-bit vector in, {e,f,g} out, using the same NOR equations. It is instantiated once.
- The FSM, vec counter, settle counter and result registers are in the top module.

## Test plan
- Fault-free chain, S=1, start pulse at cycle 0 -> done at cycle 49, pass=1, err_count=0, fail_valid=0.
- dut_g stuck at 0 -> err_count=5 (vectors 0,2,6,10,14), fail_vec=0, pass=0.
- dut_e stuck at 1 -> err_count=12, fail_vec=4, pass=0.
- S=0, fault-free chain -> done at cycle 33. Checker confirms dut_* stay stable during every CHECK and busy=1 from cycle 1 to cycle 32.
- abort at cycle 10 -> busy=0 and dut_*=0 from cycle 11, no done pulse. A later start then gives a full run with normal results.
- rst_n low mid-run at cycle 20 -> all outputs 0 immediately (asynchronous). start during busy -> ignored, with run timing unchanged.
